// File: rtl/btb_pkg.sv
// Shared types and sizing for the BTB update controller.
// Index extraction lives here so every user agrees on which PC bits select an entry.
package btb_pkg;

    localparam int BTB_SIZE   = 32;
    localparam int INDEX_BITS = $clog2(BTB_SIZE);
    localparam int FIFO_DEPTH = 4;

    typedef logic [INDEX_BITS-1:0] btb_idx_t;

    typedef struct packed {
        btb_idx_t    idx;
        logic [31:0] tgt;
    } btb_upd_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } btb_ctrl_state_t;

    // Instructions are word aligned, so the index starts above the byte offset.
    function automatic btb_idx_t pc_to_idx(input logic [31:0] pc);
        return pc[INDEX_BITS+1:2];
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending-update queue between execute and the BTB write port.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  btb_upd_t din,
    input  logic     pop,
    input  logic     clear,
    output btb_upd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    btb_upd_t      mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/btb_update_ctrl.sv
// Owns the single BTB write port: drains queued branch updates when fetch is idle
// and runs a full-array invalidate sweep on request.
module btb_update_ctrl
    import btb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ex_valid,
    input  logic                  ex_taken,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_target,
    output logic                  ex_ready,
    input  logic                  fetch_lookup,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  btb_we,
    output logic [INDEX_BITS-1:0] btb_idx,
    output logic [31:0]           btb_tgt,
    output logic                  btb_vld,
    output logic [7:0]            drop_cnt
);

    btb_ctrl_state_t state;
    btb_idx_t        sweep_cnt;

    btb_upd_t fifo_din;
    btb_upd_t fifo_dout;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_clear;
    logic     accept;
    logic     drop_evt;

    // Updates are only considered in IDLE and lose to a same-cycle flush request.
    assign accept     = ex_valid && ex_taken && (state == IDLE) && !flush_req;
    assign fifo_push  = accept && !fifo_full;
    assign drop_evt   = accept && fifo_full;
    assign fifo_pop   = (state == IDLE) && !fifo_empty && !fetch_lookup;
    assign fifo_clear = (state == IDLE) && flush_req;
    assign fifo_din   = '{idx: pc_to_idx(ex_pc), tgt: ex_target};

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_req) begin
                        state     <= FLUSH;
                        sweep_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_req) begin
                        sweep_cnt <= '0;
                    end else if (sweep_cnt == btb_idx_t'(BTB_SIZE - 1)) begin
                        state     <= IDLE;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + btb_idx_t'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Write port follows the FIFO head combinationally so an update lands the cycle after it is queued.
    always_comb begin
        btb_we  = 1'b0;
        btb_idx = '0;
        btb_tgt = '0;
        btb_vld = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_pop) begin
                    btb_we  = 1'b1;
                    btb_idx = fifo_dout.idx;
                    btb_tgt = fifo_dout.tgt;
                    btb_vld = 1'b1;
                end
            end
            FLUSH: begin
                btb_we  = 1'b1;
                btb_idx = sweep_cnt;
            end
            default: ;
        endcase
    end

    assign flush_busy = (state == FLUSH);
    assign ex_ready   = (state == IDLE) && !fifo_full;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: expected BTB writes are queued as stimulus is
// driven and matched in order against every btb_we cycle.
module tb_btb_update_ctrl;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] tgt;
        logic        vld;
    } wr_t;

    logic        clk;
    logic        rstn;
    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_ready;
    logic        fetch_lookup;
    logic        flush_req;
    logic        flush_busy;
    logic        btb_we;
    logic [4:0]  btb_idx;
    logic [31:0] btb_tgt;
    logic        btb_vld;
    logic [7:0]  drop_cnt;

    int  errors = 0;
    int  checks = 0;
    int  busy_cycles = 0;
    wr_t exp_q[$];
    wr_t keep;

    btb_update_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .ex_valid     (ex_valid),
        .ex_taken     (ex_taken),
        .ex_pc        (ex_pc),
        .ex_target    (ex_target),
        .ex_ready     (ex_ready),
        .fetch_lookup (fetch_lookup),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .btb_we       (btb_we),
        .btb_idx      (btb_idx),
        .btb_tgt      (btb_tgt),
        .btb_vld      (btb_vld),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic wr_t mk(input logic [4:0] idx, input logic [31:0] tgt, input logic vld);
        wr_t w;
        w.idx = idx;
        w.tgt = tgt;
        w.vld = vld;
        return w;
    endfunction

    function automatic logic [4:0] idx_of(input logic [31:0] pc);
        return pc[6:2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_taken(input logic [31:0] pc, input logic [31:0] tgt, input bit expect_write);
        ex_valid  = 1'b1;
        ex_taken  = 1'b1;
        ex_pc     = pc;
        ex_target = tgt;
        if (expect_write) exp_q.push_back(mk(idx_of(pc), tgt, 1'b1));
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(5'(i), 32'h0, 1'b0));
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    64'(btb_we),     64'd0);
        check({tag, "_idx"},   64'(btb_idx),    64'd0);
        check({tag, "_tgt"},   64'(btb_tgt),    64'd0);
        check({tag, "_vld"},   64'(btb_vld),    64'd0);
        check({tag, "_busy"},  64'(flush_busy), 64'd0);
        check({tag, "_ready"}, 64'(ex_ready),   64'd1);
        check({tag, "_drops"}, 64'(drop_cnt),   64'd0);
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn) begin
            if (flush_busy) busy_cycles++;
            if (btb_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(btb_we), 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write", 64'({btb_idx, btb_tgt, btb_vld}), 64'({e.idx, e.tgt, e.vld}));
                    check("busy_on_write", 64'(flush_busy), 64'(!e.vld));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn         = 1'b0;
        ex_valid     = 1'b0;
        ex_taken     = 1'b0;
        ex_pc        = '0;
        ex_target    = '0;
        fetch_lookup = 1'b0;
        flush_req    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // 1: single taken branch, fetch idle -> written the next cycle.
        drive_taken(32'h28, 32'h38, 1'b1);
        tick();
        ex_valid = 1'b0;
        check("t1_we", 64'(btb_we), 64'd1);
        check("t1_idx", 64'(btb_idx), 64'd10);
        tick();
        check("t1_empty", 64'(exp_q.size()), 64'd0);
        check("t1_idle_we", 64'(btb_we), 64'd0);

        // 2: fetch holds the port; five taken updates, the fifth is dropped.
        fetch_lookup = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_taken(32'h100 + 32'(4 * i), 32'h2000 + 32'(i), i < 4);
            if (i == 4) check("t2_not_ready", 64'(ex_ready), 64'd0);
            check("t2_held", 64'(btb_we), 64'd0);
            tick();
        end
        ex_valid = 1'b0;
        check("t2_drop1", 64'(drop_cnt), 64'd1);
        fetch_lookup = 1'b0;
        repeat (4) tick();
        check("t2_consecutive", 64'(exp_q.size()), 64'd0);
        check("t2_ready", 64'(ex_ready), 64'd1);

        // 3: flush with two updates queued; they must never be written.
        fetch_lookup = 1'b1;
        drive_taken(32'h200, 32'hAAAA, 1'b0);
        tick();
        drive_taken(32'h204, 32'hBBBB, 1'b0);
        tick();
        ex_valid    = 1'b0;
        busy_cycles = 0;
        flush_req   = 1'b1;
        push_sweep();
        tick();
        flush_req = 1'b0;
        check("t3_busy", 64'(flush_busy), 64'd1);
        wait_drain("t3", 40);
        check("t3_busy_done", 64'(flush_busy), 64'd0);
        check("t3_busy_cycles", 64'(busy_cycles), 64'd32);
        fetch_lookup = 1'b0;
        repeat (3) tick();

        // 4: second flush request at sweep index 17 restarts from 0.
        busy_cycles = 0;
        flush_req   = 1'b1;
        push_sweep();
        tick();
        flush_req = 1'b0;
        repeat (17) tick();
        check("t4_idx17", 64'(btb_idx), 64'd17);
        keep = exp_q[0];
        exp_q.delete();
        exp_q.push_back(keep);
        push_sweep();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("t4_restart", 64'(btb_idx), 64'd0);
        wait_drain("t4", 40);
        check("t4_busy_cycles", 64'(busy_cycles), 64'd50);

        // 5: flush and taken update together; update vanishes without counting as a drop.
        flush_req = 1'b1;
        drive_taken(32'h44, 32'h99, 1'b0);
        push_sweep();
        tick();
        flush_req = 1'b0;
        check("t5_ready_in_flush", 64'(ex_ready), 64'd0);
        tick();
        ex_valid = 1'b0;
        wait_drain("t5", 40);
        check("t5_drops", 64'(drop_cnt), 64'd1);
        repeat (3) tick();

        // 6: saturate the drop counter, then reset in the middle of a sweep.
        fetch_lookup = 1'b1;
        for (int i = 0; i < 304; i++) begin
            drive_taken(32'h300 + 32'(4 * (i % 8)), 32'h5000 + 32'(i), i < 4);
            tick();
        end
        ex_valid = 1'b0;
        check("t6_saturated", 64'(drop_cnt), 64'hFF);
        fetch_lookup = 1'b0;
        wait_drain("t6", 20);
        flush_req = 1'b1;
        push_sweep();
        tick();
        flush_req = 1'b0;
        repeat (5) tick();
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midsweep_reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) tick();
        check("post_reset_we", 64'(btb_we), 64'd0);
        check("post_reset_busy", 64'(flush_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
